// File: rtl/cpu_core_pkg.sv
// Shared definitions for the FourBitCPU execution core: opcode map,
// sequencer state encoding and a small opcode-decode helper.
package cpu_core_pkg;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_EXEC  = 1'b1
  } state_t;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  // ADD B,Im is the only adder use whose first operand is B.
  function automatic logic alu_uses_b(input logic [3:0] op);
    return (op == OP_ADD_B);
  endfunction

endpackage

// File: rtl/cpu_core_alu4.sv
// 4-bit adder for ADD instructions: returns the wrapped sum and bit-4 carry.
module cpu_core_alu4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] sum_o,
  output logic       carry_o
);

  logic [4:0] full_s;

  assign full_s  = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o   = full_s[3:0];
  assign carry_o = full_s[4];

endmodule

// File: rtl/cpu_core.sv
// FourBitCPU execution core: PC, A/B registers, carry flag, output port and
// a two-state FETCH/EXEC sequencer retiring one instruction per two cycles.
module cpu_core
  import cpu_core_pkg::*;
(
  input  logic       clk_cpu,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] rom_data,
  input  logic [3:0] in_port,
  output logic [3:0] rom_adrs,
  output logic [3:0] out_port,
  output logic       retire
);

  state_t     state_q, state_d;
  logic [3:0] pc_q, pc_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [7:0] ir_q, ir_d;
  logic       carry_q, carry_d;
  logic [3:0] out_q, out_d;
  logic       retire_q, retire_d;

  logic [3:0] op_s;
  logic [3:0] im_s;
  logic [3:0] alu_a_s;
  logic [3:0] alu_sum_s;
  logic       alu_carry_s;

  assign op_s    = ir_q[7:4];
  assign im_s    = ir_q[3:0];
  assign alu_a_s = alu_uses_b(op_s) ? b_q : a_q;

  cpu_core_alu4 u_alu4 (
    .a_i     (alu_a_s),
    .b_i     (im_s),
    .sum_o   (alu_sum_s),
    .carry_o (alu_carry_s)
  );

  // Sequencer and datapath next-state: latch IR in FETCH, execute IR in EXEC.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    a_d      = a_q;
    b_d      = b_q;
    ir_d     = ir_q;
    carry_d  = carry_q;
    out_d    = out_q;
    retire_d = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (run) begin
          ir_d    = rom_data;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_EXEC: begin
        state_d  = ST_FETCH;
        retire_d = 1'b1;
        carry_d  = 1'b0;
        pc_d     = pc_q + 4'd1;
        case (op_s)
          OP_ADD_A:  begin a_d = alu_sum_s; carry_d = alu_carry_s; end
          OP_MOV_AB: a_d = b_q;
          OP_IN_A:   a_d = in_port;
          OP_MOV_AI: a_d = im_s;
          OP_MOV_BA: b_d = a_q;
          OP_ADD_B:  begin b_d = alu_sum_s; carry_d = alu_carry_s; end
          OP_IN_B:   b_d = in_port;
          OP_MOV_BI: b_d = im_s;
          OP_OUT_B:  out_d = b_q;
          OP_OUT_I:  out_d = im_s;
          OP_JNC: begin
            // Branch decision uses the carry held before this instruction.
            if (!carry_q) begin
              pc_d = im_s;
            end else begin
              pc_d = pc_q + 4'd1;
            end
          end
          OP_JMP:    pc_d = im_s;
          default:   ;
        endcase
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Architectural state register; reset aborts any instruction in flight.
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state_q  <= ST_FETCH;
      pc_q     <= 4'd0;
      a_q      <= 4'd0;
      b_q      <= 4'd0;
      ir_q     <= 8'd0;
      carry_q  <= 1'b0;
      out_q    <= 4'd0;
      retire_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ir_q     <= ir_d;
      carry_q  <= carry_d;
      out_q    <= out_d;
      retire_q <= retire_d;
    end
  end

  assign rom_adrs = pc_q;
  assign out_port = out_q;
  assign retire   = retire_q;

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: a table of single-instruction steps with
// hand-computed results, plus sequences for stalls, run drop, reset and
// the full-program PC wrap.
module tb_cpu_core;

  logic       clk_cpu;
  logic       reset;
  logic       run;
  logic [7:0] rom_data;
  logic [3:0] in_port;
  logic [3:0] rom_adrs;
  logic [3:0] out_port;
  logic       retire;

  logic [7:0] mem [16];
  logic [3:0] cur_pc;
  int checks;
  int errors;

  typedef struct {
    logic [7:0] instr;
    logic [3:0] inp;
    logic [3:0] pc;
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] outp;
  } vec_t;

  vec_t vecs [21];

  assign rom_data = mem[rom_adrs];

  cpu_core dut (
    .clk_cpu  (clk_cpu),
    .reset    (reset),
    .run      (run),
    .rom_data (rom_data),
    .in_port  (in_port),
    .rom_adrs (rom_adrs),
    .out_port (out_port),
    .retire   (retire)
  );

  initial clk_cpu = 1'b0;
  always #5 clk_cpu = ~clk_cpu;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Fetch then execute one instruction placed at the current PC.
  task automatic step(input logic [7:0] instr, input logic [3:0] inp);
    mem[cur_pc] = instr;
    in_port = inp;
    run = 1'b1;
    @(posedge clk_cpu); #1;
    chk("fetch_pc_hold", {4'd0, rom_adrs}, {4'd0, cur_pc});
    chk("fetch_retire", {7'd0, retire}, 8'd0);
    @(posedge clk_cpu); #1;
  endtask

  task automatic do_reset();
    run = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk_cpu);
    #1;
    chk("rst_pc", {4'd0, rom_adrs}, 8'd0);
    chk("rst_out", {4'd0, out_port}, 8'd0);
    chk("rst_retire", {7'd0, retire}, 8'd0);
    @(negedge clk_cpu);
    reset = 1'b0;
    cur_pc = 4'd0;
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    run = 1'b0;
    in_port = 4'd0;
    cur_pc = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h80;

    //            instr  in     pc     a      b      c     out
    vecs[0]  = '{8'h39, 4'h0, 4'h1, 4'h9, 4'h0, 1'b0, 4'h0}; // MOV A,9
    vecs[1]  = '{8'h08, 4'h0, 4'h2, 4'h1, 4'h0, 1'b1, 4'h0}; // ADD A,8 -> 17
    vecs[2]  = '{8'hE0, 4'h0, 4'h3, 4'h1, 4'h0, 1'b0, 4'h0}; // JNC 0, carry set
    vecs[3]  = '{8'h33, 4'h0, 4'h4, 4'h3, 4'h0, 1'b0, 4'h0}; // MOV A,3
    vecs[4]  = '{8'hEA, 4'h0, 4'hA, 4'h3, 4'h0, 1'b0, 4'h0}; // JNC A taken
    vecs[5]  = '{8'h64, 4'h6, 4'hB, 4'h3, 4'h6, 1'b0, 4'h0}; // IN B
    vecs[6]  = '{8'h90, 4'h0, 4'hC, 4'h3, 4'h6, 1'b0, 4'h6}; // OUT B
    vecs[7]  = '{8'hB5, 4'h0, 4'hD, 4'h3, 4'h6, 1'b0, 4'h5}; // OUT 5
    vecs[8]  = '{8'h41, 4'h0, 4'hE, 4'h3, 4'h3, 1'b0, 4'h5}; // MOV B,A
    vecs[9]  = '{8'h1F, 4'h0, 4'hF, 4'h3, 4'h3, 1'b0, 4'h5}; // MOV A,B
    vecs[10] = '{8'h0E, 4'h0, 4'h0, 4'h1, 4'h3, 1'b1, 4'h5}; // ADD A,14, PC wraps
    vecs[11] = '{8'h8F, 4'h0, 4'h1, 4'h1, 4'h3, 1'b0, 4'h5}; // NOP clears carry
    vecs[12] = '{8'h5F, 4'h0, 4'h2, 4'h1, 4'h2, 1'b1, 4'h5}; // ADD B,15 -> 18
    vecs[13] = '{8'hF7, 4'h0, 4'h7, 4'h1, 4'h2, 1'b0, 4'h5}; // JMP 7
    vecs[14] = '{8'h25, 4'hC, 4'h8, 4'hC, 4'h2, 1'b0, 4'h5}; // IN A
    vecs[15] = '{8'h7D, 4'h0, 4'h9, 4'hC, 4'hD, 1'b0, 4'h5}; // MOV B,D
    vecs[16] = '{8'hE3, 4'h0, 4'h3, 4'hC, 4'hD, 1'b0, 4'h5}; // JNC 3 taken
    vecs[17] = '{8'hC0, 4'h0, 4'h4, 4'hC, 4'hD, 1'b0, 4'h5}; // NOP
    vecs[18] = '{8'h0A, 4'h0, 4'h5, 4'h6, 4'hD, 1'b1, 4'h5}; // ADD A,10 -> 22
    vecs[19] = '{8'hD2, 4'h0, 4'h6, 4'h6, 4'hD, 1'b0, 4'h5}; // NOP
    vecs[20] = '{8'h7F, 4'h0, 4'h7, 4'h6, 4'hF, 1'b0, 4'h5}; // MOV B,F

    do_reset();
    chk("rst_a", {4'd0, dut.a_q}, 8'd0);
    chk("rst_b", {4'd0, dut.b_q}, 8'd0);
    chk("rst_c", {7'd0, dut.carry_q}, 8'd0);

    // Table-driven instruction steps.
    for (int i = 0; i < 21; i++) begin
      step(vecs[i].instr, vecs[i].inp);
      chk($sformatf("v%0d_pc", i), {4'd0, rom_adrs}, {4'd0, vecs[i].pc});
      chk($sformatf("v%0d_a", i), {4'd0, dut.a_q}, {4'd0, vecs[i].a});
      chk($sformatf("v%0d_b", i), {4'd0, dut.b_q}, {4'd0, vecs[i].b});
      chk($sformatf("v%0d_c", i), {7'd0, dut.carry_q}, {7'd0, vecs[i].c});
      chk($sformatf("v%0d_out", i), {4'd0, out_port}, {4'd0, vecs[i].outp});
      chk($sformatf("v%0d_retire", i), {7'd0, retire}, 8'd1);
      cur_pc = vecs[i].pc;
    end

    // run dropped during EXEC: instruction still completes.
    mem[cur_pc] = 8'h3E;
    run = 1'b1;
    @(posedge clk_cpu); #1;
    run = 1'b0;
    @(posedge clk_cpu); #1;
    chk("rundrop_a", {4'd0, dut.a_q}, 8'h0E);
    chk("rundrop_pc", {4'd0, rom_adrs}, {4'd0, cur_pc + 4'd1});
    chk("rundrop_retire", {7'd0, retire}, 8'd1);
    cur_pc = cur_pc + 4'd1;

    // Stall five cycles in FETCH, then measure retire latency.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_cpu); #1;
      chk($sformatf("stall%0d_pc", i), {4'd0, rom_adrs}, {4'd0, cur_pc});
      chk($sformatf("stall%0d_retire", i), {7'd0, retire}, 8'd0);
    end
    mem[cur_pc] = 8'h80;
    run = 1'b1;
    n = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk_cpu); #1;
      if (retire && n == 0) n = i;
    end
    chk("stall_retire_latency", n[7:0], 8'd2);
    run = 1'b0;
    @(posedge clk_cpu); #1;
    cur_pc = rom_adrs;

    // Asynchronous reset in the middle of EXEC of ADD A,15.
    mem[cur_pc] = 8'h0F;
    run = 1'b1;
    @(posedge clk_cpu); #2;
    reset = 1'b1;
    #1;
    chk("arst_pc", {4'd0, rom_adrs}, 8'd0);
    chk("arst_out", {4'd0, out_port}, 8'd0);
    chk("arst_retire", {7'd0, retire}, 8'd0);
    chk("arst_a", {4'd0, dut.a_q}, 8'd0);
    chk("arst_c", {7'd0, dut.carry_q}, 8'd0);
    run = 1'b0;
    @(posedge clk_cpu);
    @(negedge clk_cpu);
    reset = 1'b0;
    cur_pc = 4'd0;
    @(posedge clk_cpu); #1;
    chk("postrst_idle_pc", {4'd0, rom_adrs}, 8'd0);
    step(8'h37, 4'h0);
    chk("postrst_a", {4'd0, dut.a_q}, 8'h07);
    chk("postrst_pc", {4'd0, rom_adrs}, 8'h01);

    // Stock-style program run from reset, including the full PC wrap.
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h80;
    mem[0] = 8'h30;  // MOV A,0
    mem[1] = 8'h0F;  // ADD A,15
    mem[3] = 8'h00;  // ADD A,0
    mem[4] = 8'h70;  // MOV B,0
    mem[5] = 8'h5F;  // ADD B,15
    run = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk_cpu);
      @(posedge clk_cpu); #1;
      if (i == 1) begin
        chk("prog_add15_a", {4'd0, dut.a_q}, 8'h0F);
        chk("prog_add15_c", {7'd0, dut.carry_q}, 8'd0);
      end
      if (i == 3) begin
        chk("prog_add0_a", {4'd0, dut.a_q}, 8'h0F);
        chk("prog_add0_c", {7'd0, dut.carry_q}, 8'd0);
      end
      if (i == 5) chk("prog_addb15_b", {4'd0, dut.b_q}, 8'h0F);
      if (i == 14) chk("prog_pc_f", {4'd0, rom_adrs}, 8'h0F);
      if (i == 15) chk("prog_pc_wrap", {4'd0, rom_adrs}, 8'h00);
    end
    run = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
# cpu_core

Execution core of the FourBitCPU. It drives the 4-bit instruction address into `rom` and consumes the 8-bit instruction word that `rom` returns combinationally. It holds the program counter, registers A and B, the carry flag and the output port. It runs a two-state fetch/execute sequencer, so it retires one instruction every two `clk_cpu` cycles while `run` is high.

## Interface
- No parameters. Widths are fixed by the 4-bit architecture.
- `clk_cpu`  in  1  core clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-high reset
- `run`  in  1  fetch enable; sampled only in FETCH
- `rom_data`  in  8  instruction from `rom.dat_out`: [7:4] opcode, [3:0] immediate
- `in_port`  in  4  external input, read by IN instructions
- `rom_adrs`  out  4  program counter, to `rom.adrs`
- `out_port`  out  4  registered output port
- `retire`  out  1  one-cycle pulse, high in the cycle after an EXEC completes

## Operation
- State machine: FETCH ↔ EXEC.
  - FETCH with `run`=1: IR ← `rom_data`; go to EXEC.
  - FETCH with `run`=0: hold all state; stay in FETCH.
  - EXEC: execute IR; update PC; go to FETCH unconditionally. `run` is ignored in EXEC.
- Opcodes (IR[7:4]); Im = IR[3:0]:
  - 0000 ADD A,Im
  - 0001 MOV A,B
  - 0010 IN A
  - 0011 MOV A,Im
  - 0100 MOV B,A
  - 0101 ADD B,Im
  - 0110 IN B
  - 0111 MOV B,Im
  - 1001 OUT B
  - 1011 OUT Im
  - 1110 JNC Im
  - 1111 JMP Im
  - 1000, 1010, 1100, 1101: NOP.
- ADD rules:
  - 5-bit sum {c, r} = dst + Im.
  - dst ← r and carry ← c.
  - Sum wraps mod 16; carry holds the bit-4 overflow.
- Carry for all other opcodes: every non-ADD instruction, including JNC, JMP and NOP, clears carry to 0.
- JNC evaluates the carry value held before this EXEC.
  - carry=0: PC ← Im.
  - carry=1: PC ← PC+1.
- JMP: PC ← Im.
- PC for every other instruction: PC ← PC+1, wrapping 4'hF → 4'h0.
- IN reads `in_port` as sampled at the EXEC clock edge.
- `out_port` changes only on OUT instructions and holds its value otherwise.

## Timing
- Reset values:
  - PC, A, B, IR, carry, `out_port`: 0
  - `retire`: 0
  - state: FETCH
- Reset asserted mid-EXEC aborts the instruction; no partial register update is kept.
- `rom_adrs` = PC register; it changes only on the EXEC edge.
- `rom_data` must settle within the FETCH cycle (rom is combinational).
- Latency:
  - Instruction at address n is fetched at edge k and executed at edge k+1.
  - Its results (A, B, carry, `out_port`) are visible after edge k+1.
  - `retire`=1 during cycle k+1 → k+2.
- Throughput: one instruction per 2 cycles with `run` held high.
- Each cycle of `run`=0 while in FETCH adds exactly one stall cycle.
- Dropping `run` during EXEC still completes that instruction.
- First fetch after reset release: address 0 at the first rising edge with `run`=1.

## Structure
- Opcode constants (`OP_*`) and the state encodings (`ST_FETCH`, `ST_EXEC`) live in `defines.v`, shared with `rom`.
- One sub-module, `alu4`: 4-bit adder producing {carry, sum} for ADD.
- All muxing, PC logic and the FSM stay in `cpu_core`.
- Top level connects `cpu_core.rom_adrs` → `rom.adrs` and `rom.dat_out` → `cpu_core.rom_data`.

## Test plan
- Reset then `run`=1 on the stock ROM program:
  - after the ADD A,15 at address 1: A=4'hF, carry=0.
  - after the ADD A,0 at address 3: A=4'hF, carry=0.
  - after the ADD B,15 at address 5: B=4'hF.
  - PC wraps from 4'hF to 4'h0 after 32 cycles.
- MOV A,9 then ADD A,8 then JNC 4'h0:
  - after the ADD: A=4'h1, carry=1.
  - JNC falls through to PC+1, and carry=0 afterwards.
- MOV A,3 then JNC 4'hA: PC=4'hA after that EXEC.
- `in_port`=4'h6, then IN B; OUT B; OUT Im=4'h5: `out_port`=6 after the first OUT and 5 after the second.
- `run` held low for 5 cycles in FETCH, then high: PC unchanged during the stall; next `retire` exactly 2 cycles after `run` rises.
- Reset asserted asynchronously during EXEC of ADD A,15:
  - all outputs read 0 immediately.
  - after release, the first fetch is from address 0.
